// File: rtl/screen_draw_scheduler_pkg.sv
// rtl/screen_draw_scheduler_pkg.sv - shared screen codes, FSM states and frame geometry
package screen_draw_scheduler_pkg;

  localparam int H_RES_DEF    = 160;
  localparam int V_RES_DEF    = 120;
  localparam int ADDR_W_DEF   = 15;
  localparam int COLOUR_W_DEF = 3;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'b00,
    SCR_BG    = 2'b01,
    SCR_WIN   = 2'b10,
    SCR_LOSE  = 2'b11
  } screen_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

endpackage

// File: rtl/screen_draw_scheduler_sweep_addr_gen.sv
// rtl/screen_draw_scheduler_sweep_addr_gen.sv - raster x/y counters with a linear ROM address
module sweep_addr_gen #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [7:0]        o_x,
  output logic [6:0]        o_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last_x;
  logic              w_last_y;

  assign w_last_x = (r_x == 8'(H_RES - 1));
  assign w_last_y = (r_y == 7'(V_RES - 1));

  // Address advances alongside x/y so no y*H_RES multiply is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? 7'd0 : r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
      r_addr <= (w_last_x && w_last_y) ? '0 : r_addr + ADDR_W'(1);
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;
  assign o_last = w_last_x & w_last_y;

endmodule

// File: rtl/screen_draw_scheduler.sv
// rtl/screen_draw_scheduler.sv - arbitrates the vga_adapter write port between ROM sweeps and sprites
import screen_draw_scheduler_pkg::*;

module screen_draw_scheduler #(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESETN,
  input  logic [1:0]          SCREEN,
  input  logic                redraw_req,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_colour,
  input  logic                spr_req,
  input  logic [7:0]          spr_x,
  input  logic [6:0]          spr_y,
  input  logic [COLOUR_W-1:0] spr_colour,
  output logic                spr_grant,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                frame_done
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_pending;
  logic                w_pending_nxt;
  logic [1:0]          r_screen;
  logic                w_trigger;
  logic                w_start;
  logic                w_accept;
  logic                w_issue;
  logic [7:0]          w_sw_x;
  logic [6:0]          w_sw_y;
  logic                w_sw_last;
  logic [7:0]          r_x;
  logic [6:0]          r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_from_rom;
  logic                r_frame_done;

  sweep_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk   (CLOCK_50),
    .i_rst_n (RESETN),
    .i_clr   (w_start),
    .i_en    (r_state == ST_SWEEP),
    .o_x     (w_sw_x),
    .o_y     (w_sw_y),
    .o_addr  (rom_addr),
    .o_last  (w_sw_last)
  );

  assign w_trigger = (SCREEN != r_screen) | redraw_req;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b1;
      r_screen  <= SCR_TITLE;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_screen  <= SCREEN;
    end
  end

  // A trigger while sweeping restarts in place; only idle triggers go through pending.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    spr_grant   = 1'b0;
    busy        = r_pending;
    case (r_state)
      ST_IDLE: begin
        spr_grant = ~r_pending;
        if (r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        busy = 1'b1;
        if (w_trigger) begin
          w_start = 1'b1;
        end else if (w_sw_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (w_trigger) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SWEEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_pending_nxt = (r_pending | (w_trigger & (r_state == ST_IDLE))) & ~w_start;
  end

  assign w_accept = spr_req & spr_grant;
  assign w_issue  = (r_state == ST_SWEEP) & ~w_trigger;

  // Sweep coordinates are delayed one stage so they line up with the ROM read data.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_from_rom   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_FLUSH) & ~w_trigger;
      if (r_from_rom) begin
        r_colour <= rom_colour;
      end
      if (w_issue) begin
        r_x        <= w_sw_x;
        r_y        <= w_sw_y;
        r_plot     <= 1'b1;
        r_from_rom <= 1'b1;
      end else if (w_accept) begin
        r_x        <= spr_x;
        r_y        <= spr_y;
        r_colour   <= spr_colour;
        r_plot     <= 1'b1;
        r_from_rom <= 1'b0;
      end else begin
        r_plot     <= 1'b0;
        r_from_rom <= 1'b0;
      end
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_from_rom ? rom_colour : r_colour;
  assign vga_plot   = r_plot;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_screen_draw_scheduler.sv
// tb/tb_screen_draw_scheduler.sv - directed bench for screen_draw_scheduler
module tb_screen_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  screen;
  logic        redraw;
  logic [14:0] rom_addr;
  logic [2:0]  rom_colour = 3'd0;
  logic        spr_req;
  logic [7:0]  spr_x;
  logic [6:0]  spr_y;
  logic [2:0]  spr_colour;
  logic        spr_grant;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  screen_draw_scheduler dut (
    .CLOCK_50   (clk),
    .RESETN     (rst_n),
    .SCREEN     (screen),
    .redraw_req (redraw),
    .rom_addr   (rom_addr),
    .rom_colour (rom_colour),
    .spr_req    (spr_req),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_colour (spr_colour),
    .spr_grant  (spr_grant),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [2:0] rom_f(input logic [1:0] s, input int a);
    return 3'((a / 7) + int'(s) * 3);
  endfunction

  always @(posedge clk) rom_colour <= rom_f(screen, int'(rom_addr));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int   sw_plots, sw_first, sw_last, sw_done, sw_bad, sw_gr_before;
  logic sw_busy_done, sw_grant_done;

  task automatic sweep_watch(input logic [1:0] scr);
    int cyc = 0;
    sw_plots = 0; sw_first = -1; sw_last = -1; sw_done = -1; sw_bad = 0;
    sw_gr_before = 0; sw_busy_done = 1'b1; sw_grant_done = 1'b0;
    while (cyc < 20000 && sw_done < 0) begin
      @(negedge clk);
      cyc++;
      if (vga_plot) begin
        if (sw_first < 0) sw_first = cyc;
        if (vga_x != 8'(sw_plots % 160) || vga_y != 7'(sw_plots / 160) ||
            vga_colour != rom_f(scr, sw_plots)) sw_bad++;
        sw_plots++;
        sw_last = cyc;
      end
      if (frame_done) begin
        sw_done       = cyc;
        sw_busy_done  = busy;
        sw_grant_done = spr_grant;
      end else if (spr_grant) begin
        sw_gr_before++;
      end
    end
  endtask

  task automatic sweep_report(input string tag, input int exp_first);
    chk({tag, "_first_plot"}, sw_first, exp_first);
    chk({tag, "_plots"}, sw_plots, 19200);
    chk({tag, "_order_errs"}, sw_bad, 0);
    chk({tag, "_done_at_last+1"}, sw_done, sw_last + 1);
    chk({tag, "_busy_at_done"}, int'(sw_busy_done), 0);
    chk({tag, "_grant_in_sweep"}, sw_gr_before, 0);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         ex;
    int         ey;
    int         ec;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int idx;
    int pre_done;
    vecs[0] = '{x: 8'd40,  y: 7'd30,  c: 3'b101, ex: 40,  ey: 30,  ec: 5};
    vecs[1] = '{x: 8'd41,  y: 7'd30,  c: 3'b101, ex: 41,  ey: 30,  ec: 5};
    vecs[2] = '{x: 8'd42,  y: 7'd30,  c: 3'b101, ex: 42,  ey: 30,  ec: 5};
    vecs[3] = '{x: 8'd200, y: 7'd127, c: 3'b010, ex: 200, ey: 127, ec: 2};
    vecs[4] = '{x: 8'd0,   y: 7'd0,   c: 3'b111, ex: 0,   ey: 0,   ec: 7};

    rst_n = 1'b0; screen = 2'b00; redraw = 1'b0;
    spr_req = 1'b0; spr_x = '0; spr_y = '0; spr_colour = '0;

    // Test 1: reset values and the automatic title sweep
    repeat (3) @(negedge clk);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_grant", int'(spr_grant), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_c1_plot", int'(vga_plot), 0);
    chk("t1_c1_rom_addr", int'(rom_addr), 0);
    chk("t1_c1_busy", int'(busy), 1);
    sweep_watch(2'b00);
    sweep_report("t1", 1);
    @(negedge clk);
    chk("t1_done_pulse", int'(frame_done), 0);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_plot_after", int'(vga_plot), 0);

    // Test 2: back-to-back sprite pixels in idle
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        chk("t2_plot", int'(vga_plot), 1);
        chk("t2_x", int'(vga_x), vecs[i-1].ex);
        chk("t2_y", int'(vga_y), vecs[i-1].ey);
        chk("t2_colour", int'(vga_colour), vecs[i-1].ec);
      end
      if (i < 5) begin
        spr_req = 1'b1; spr_x = vecs[i].x; spr_y = vecs[i].y; spr_colour = vecs[i].c;
        #1;
        chk("t2_grant", int'(spr_grant), 1);
      end else begin
        spr_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("t2_plot_idle", int'(vga_plot), 0);
    chk("t2_x_hold", int'(vga_x), 0);
    chk("t2_colour_hold", int'(vga_colour), 7);

    // Test 3: sprite held through a requested sweep
    redraw = 1'b1;
    @(negedge clk);
    redraw = 1'b0;
    spr_req = 1'b1; spr_x = 8'd10; spr_y = 7'd20; spr_colour = 3'd6;
    sweep_watch(2'b00);
    sweep_report("t3", 2);
    chk("t3_grant_at_done", int'(sw_grant_done), 1);
    @(negedge clk);
    spr_req = 1'b0;
    chk("t3_spr_plot", int'(vga_plot), 1);
    chk("t3_spr_x", int'(vga_x), 10);
    chk("t3_spr_y", int'(vga_y), 20);
    chk("t3_spr_colour", int'(vga_colour), 6);
    chk("t3_done_pulse", int'(frame_done), 0);

    // Test 4: screen change at sweep pixel 5000 aborts and restarts
    redraw = 1'b1;
    @(negedge clk);
    redraw = 1'b0;
    idx = 0; pre_done = 0;
    for (int c = 0; c < 6000 && idx <= 5000; c++) begin
      @(negedge clk);
      if (frame_done) pre_done++;
      if (vga_plot) begin
        if (idx == 5000) begin
          chk("t4_px5000_x", int'(vga_x), 40);
          chk("t4_px5000_y", int'(vga_y), 31);
          screen = 2'b01;
        end
        idx++;
      end
    end
    chk("t4_reached_5000", idx, 5001);
    @(negedge clk);
    chk("t4_dropped_plot", int'(vga_plot), 0);
    chk("t4_busy", int'(busy), 1);
    sweep_watch(2'b01);
    sweep_report("t4", 1);
    chk("t4_no_early_done", pre_done, 0);
    @(negedge clk);
    chk("t4_done_pulse", int'(frame_done), 0);

    // Test 5: redraw in the same cycle as a sprite accept
    spr_req = 1'b1; spr_x = 8'd5; spr_y = 7'd6; spr_colour = 3'd1; redraw = 1'b1;
    #1;
    chk("t5_grant", int'(spr_grant), 1);
    @(negedge clk);
    spr_req = 1'b0; redraw = 1'b0;
    chk("t5_spr_plot", int'(vga_plot), 1);
    chk("t5_spr_x", int'(vga_x), 5);
    chk("t5_spr_y", int'(vga_y), 6);
    chk("t5_grant_pending", int'(spr_grant), 0);
    @(negedge clk);
    chk("t5_gap_plot", int'(vga_plot), 0);
    @(negedge clk);
    chk("t5_sweep_plot", int'(vga_plot), 1);
    chk("t5_sweep_x", int'(vga_x), 0);
    chk("t5_sweep_y", int'(vga_y), 0);
    chk("t5_sweep_colour", int'(vga_colour), int'(rom_f(2'b01, 0)));

    // Test 6: asynchronous reset mid-sweep
    repeat (50) @(negedge clk);
    chk("t6_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_plot", int'(vga_plot), 0);
    chk("t6_rst_x", int'(vga_x), 0);
    chk("t6_rst_colour", int'(vga_colour), 0);
    chk("t6_rst_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_c1_plot", int'(vga_plot), 0);
    sweep_watch(2'b01);
    sweep_report("t6", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
